// File: rtl/iic_eeprom_ctrl_if.sv
// Request/response handshake plus the byte-level I2C master connection for iic_eeprom_ctrl.
// slave = controller view, master = requester/test view.
interface iic_eeprom_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;
  logic [1:0] m_call;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  logic       m_done;
  logic [7:0] m_rdata;
  logic       m_rst_n;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, m_done, m_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           m_call, m_addr, m_wdata, m_rst_n
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, m_done, m_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           m_call, m_addr, m_wdata, m_rst_n
  );
endinterface

// File: rtl/iic_eeprom_ctrl.sv
// Single-byte EEPROM transaction controller in front of the byte-level I2C master.
// Enforces tWR after writes and aborts hung calls by timeout plus a master reset pulse.
module iic_eeprom_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned TWR_CYC     = 250000
) (
  input logic               clk,
  input logic               rst,
  iic_eeprom_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALL, TWR, ABORT} state_t;

  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYC - 1);
  localparam logic [19:0] TWR_LAST     = 20'(TWR_CYC - 1);

  state_t      state_q, state_d;
  logic [19:0] timer_q, timer_d;
  logic [1:0]  call_q, call_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      call_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      call_q      <= call_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    call_d      = call_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          call_d  = bus.req_wr ? 2'b10 : 2'b01;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          timer_d = '0;
          state_d = CALL;
        end
      end
      CALL: begin
        timer_d = timer_q + 20'd1;
        // A completion in the terminal-count cycle beats the timeout.
        if (bus.m_done) begin
          call_d      = 2'b00;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = call_q[1] ? 8'h00 : bus.m_rdata;
          if (call_q[1]) begin
            timer_d = '0;
            state_d = TWR;
          end else begin
            state_d = IDLE;
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          call_d      = 2'b00;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
          state_d     = ABORT;
        end
      end
      TWR: begin
        if (timer_q == TWR_LAST) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 20'd1;
        end
      end
      ABORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.m_call    = call_q;
  assign bus.m_addr    = addr_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  // Master is held in reset through system reset and for the single ABORT cycle.
  assign bus.m_rst_n   = ~(rst | (state_q == ABORT));

endmodule

// File: tb/tb_iic_eeprom_ctrl.sv
// Directed bench for iic_eeprom_ctrl with a delayed-done master model and a response scoreboard.
module tb_iic_eeprom_ctrl;

  localparam int TO_CYC  = 200;
  localparam int TWR_CYC = 50;

  typedef struct packed {
    logic       err;
    logic [7:0] rdata;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  iic_eeprom_ctrl_if bus ();

  iic_eeprom_ctrl #(
    .TIMEOUT_CYC (TO_CYC),
    .TWR_CYC     (TWR_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp  = 0;
  int         n_fail = 0;
  rsp_t       sb[$];
  int         model_n = -1;
  logic [7:0] model_rdata = 8'h00;

  // Master model: m_done is high during the N-th cycle (0-based) after m_call goes nonzero.
  initial begin : master_model
    int cnt;
    cnt = 0;
    bus.m_done  = 1'b0;
    bus.m_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.m_call != 2'b00) begin
        bus.m_done = (cnt == model_n);
        cnt++;
      end else begin
        bus.m_done = 1'b0;
        cnt = 0;
      end
      bus.m_rdata = bus.m_done ? model_rdata : 8'h00;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request at the current negedge; returns at the first CALL cycle.
  task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                       input logic exp_err, input logic [7:0] exp_rdata);
    rsp_t e;
    check("issue_ready", {31'd0, bus.req_ready}, 32'd1);
    e.err   = exp_err;
    e.rdata = exp_rdata;
    sb.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("call_code", {30'd0, bus.m_call}, wr ? 32'd2 : 32'd1);
    check("call_addr", {24'd0, bus.m_addr}, {24'd0, addr});
    check("call_wdata", {24'd0, bus.m_wdata}, {24'd0, wdata});
    check("call_ready_low", {31'd0, bus.req_ready}, 32'd0);
    check("call_busy", {31'd0, bus.busy}, 32'd1);
  endtask

  // Waits for rsp_valid, counting cycles since the first CALL cycle, and scores the response.
  task automatic wait_rsp(input int budget, output int cycles, output int rstn_low);
    rsp_t e;
    logic got;
    got = 1'b0;
    cycles = 0;
    rstn_low = 0;
    while (!got && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (!bus.m_rst_n) rstn_low++;
      if (bus.rsp_valid) got = 1'b1;
    end
    if (got) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        check("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, e.rdata});
      end
      check("rsp_call_clear", {30'd0, bus.m_call}, 32'd0);
    end else begin
      check("rsp_timeout", 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  initial begin : stimulus
    int cyc;
    int low;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_mrstn", {31'd0, bus.m_rst_n}, 32'd0);
    check("rst_call", {30'd0, bus.m_call}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("init_ready", {31'd0, bus.req_ready}, 32'd1);
    check("init_busy", {31'd0, bus.busy}, 32'd0);
    check("init_call", {30'd0, bus.m_call}, 32'd0);
    check("init_addr", {24'd0, bus.m_addr}, 32'd0);
    check("init_wdata", {24'd0, bus.m_wdata}, 32'd0);
    check("init_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("init_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    check("init_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("init_mrstn", {31'd0, bus.m_rst_n}, 32'd1);

    // Write 0x5A to 0x10, done after 100 cycles, then 50 cycles of tWR
    model_n = 100;
    issue(1'b1, 8'h10, 8'h5A, 1'b0, 8'h00);
    wait_rsp(300, cyc, low);
    $display("write a=10 d=5a: rsp after %0d cycles", cyc);
    check("wr_latency", cyc, 32'd101);
    check("wr_no_mrst", low, 32'd0);
    for (int k = 1; k <= TWR_CYC; k++) begin
      @(negedge clk);
      if (k < TWR_CYC) check("wr_twr_ready_low", {31'd0, bus.req_ready}, 32'd0);
      else             check("wr_twr_ready_back", {31'd0, bus.req_ready}, 32'd1);
      if (k == 1) check("wr_rsp_one_cycle", {31'd0, bus.rsp_valid}, 32'd0);
    end

    // Read 0x22 returning 0xC3
    model_n = 5;
    model_rdata = 8'hC3;
    issue(1'b0, 8'h22, 8'h00, 1'b0, 8'hC3);
    wait_rsp(300, cyc, low);
    $display("read a=22: rsp after %0d cycles rdata=%0h", cyc, bus.rsp_rdata);
    check("rd_latency", cyc, 32'd6);
    @(negedge clk);
    check("rd_ready_after", {31'd0, bus.req_ready}, 32'd1);
    check("rd_rsp_one_cycle", {31'd0, bus.rsp_valid}, 32'd0);
    check("rd_rdata_hold", {24'd0, bus.rsp_rdata}, 32'hC3);

    // Hung device: no m_done ever
    model_n = -1;
    issue(1'b0, 8'h33, 8'h00, 1'b1, 8'h00);
    wait_rsp(300, cyc, low);
    $display("read a=33 no done: rsp after %0d cycles err=%0d", cyc, bus.rsp_err);
    check("to_latency", cyc, TO_CYC);
    check("to_mrstn_low_at_rsp", {31'd0, bus.m_rst_n}, 32'd0);
    check("to_mrstn_low_count", low, 32'd1);
    @(negedge clk);
    check("to_mrstn_release", {31'd0, bus.m_rst_n}, 32'd1);
    check("to_idle_busy", {31'd0, bus.busy}, 32'd0);
    check("to_idle_ready", {31'd0, bus.req_ready}, 32'd1);
    check("to_err_hold", {31'd0, bus.rsp_err}, 32'd1);

    // m_done on the terminal-count cycle wins over the timeout
    model_n = TO_CYC - 1;
    model_rdata = 8'h7E;
    issue(1'b0, 8'h44, 8'h00, 1'b0, 8'h7E);
    wait_rsp(300, cyc, low);
    $display("read a=44 done at tc: rsp after %0d cycles err=%0d", cyc, bus.rsp_err);
    check("tc_latency", cyc, TO_CYC);
    check("tc_no_mrst", low, 32'd0);
    @(negedge clk);
    check("tc_mrstn_high", {31'd0, bus.m_rst_n}, 32'd1);
    check("tc_idle", {31'd0, bus.busy}, 32'd0);

    // Back-to-back write then read with req_valid held high throughout tWR
    model_n = 3;
    sb.push_back('{err: 1'b0, rdata: 8'h00});
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 8'h30;
    bus.req_wdata = 8'hA5;
    @(negedge clk);
    check("b2b_wr_call", {30'd0, bus.m_call}, 32'd2);
    check("b2b_wr_wdata", {24'd0, bus.m_wdata}, 32'hA5);
    bus.req_wr    = 1'b0;
    bus.req_addr  = 8'h55;
    bus.req_wdata = 8'hEE;
    sb.push_back('{err: 1'b0, rdata: 8'h3C});
    wait_rsp(300, cyc, low);
    $display("b2b write a=30 d=a5: rsp after %0d cycles", cyc);
    check("b2b_wr_latency", cyc, 32'd4);
    model_n = 4;
    model_rdata = 8'h3C;
    for (int k = 1; k <= TWR_CYC; k++) begin
      @(negedge clk);
      if (k < TWR_CYC) begin
        check("b2b_ready_low", {31'd0, bus.req_ready}, 32'd0);
        check("b2b_no_early_call", {30'd0, bus.m_call}, 32'd0);
      end else begin
        check("b2b_ready_back", {31'd0, bus.req_ready}, 32'd1);
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("b2b_rd_call", {30'd0, bus.m_call}, 32'd1);
    check("b2b_rd_addr", {24'd0, bus.m_addr}, 32'h55);
    wait_rsp(300, cyc, low);
    $display("b2b read a=55: rsp after %0d cycles rdata=%0h", cyc, bus.rsp_rdata);
    check("b2b_rd_latency", cyc, 32'd5);

    // Reset in the middle of a CALL
    @(negedge clk);
    model_n = -1;
    issue(1'b0, 8'h66, 8'h00, 1'b1, 8'h00);
    repeat (39) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_call_async", {30'd0, bus.m_call}, 32'd0);
    check("mid_rst_mrstn", {31'd0, bus.m_rst_n}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    sb.delete();
    @(negedge clk);
    check("mid_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    check("mid_rst_mrstn_hold", {31'd0, bus.m_rst_n}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      check("post_rst_mrstn", {31'd0, bus.m_rst_n}, 32'd1);
    end
    $display("reset mid-call: released");

    model_n = 10;
    model_rdata = 8'h81;
    issue(1'b0, 8'h77, 8'h00, 1'b0, 8'h81);
    wait_rsp(300, cyc, low);
    $display("read a=77 after reset: rsp after %0d cycles rdata=%0h", cyc, bus.rsp_rdata);
    check("post_rst_rd_latency", cyc, 32'd11);

    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
